posit_raw_encode_es2: RTL and testbench



---
 rtl/posit_raw_encode_es2_pkg.sv | 40 ++++
 rtl/posit_raw_encode_es2_if.sv | 21 ++
 rtl/posit_raw_encode_es2_shift_right.sv | 21 ++
 rtl/posit_raw_encode_es2.sv | 146 ++++++++++++++
 tb/tb_posit_raw_encode_es2.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_raw_encode_es2_pkg.sv
// Shared constants and the raw-sum layout for the es=2 posit encoder.
// The raw sum is {sgn, scale, fraction (hidden bit excluded), inf, zero}.
package posit_raw_encode_es2_pkg;

  localparam int POSIT_N_ES2 = 32;
  localparam int POSIT_ES_ES2 = 2;
  localparam int ABITS = 32;
  localparam int SCALE_W = 8;
  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES2 = 1 + SCALE_W + ABITS + 2;

  localparam logic [POSIT_N_ES2-1:0] POSIT_MAXPOS_ES2 = 32'h7FFF_FFFF;
  localparam logic [POSIT_N_ES2-1:0] POSIT_MINPOS_ES2 = 32'h0000_0001;
  localparam logic [POSIT_N_ES2-1:0] POSIT_NAR_ES2    = 32'h8000_0000;
  localparam logic signed [SCALE_W-1:0] SCALE_MAX_ES2 = 8'sd120;

  // Regime shifter: the magnitude string is built in a 2N-bit window.
  localparam int SHIFT_W = 2 * POSIT_N_ES2;
  localparam int SHAMT_W = 6;
  localparam int PAD_W   = SHIFT_W - 1 - POSIT_ES_ES2 - ABITS;

  typedef struct packed {
    logic               sgn;
    logic [SCALE_W-1:0] scale;
    logic [ABITS-1:0]   fraction;
    logic               inf;
    logic               zero;
  } value_sum;

  // Length of the run of identical regime bits: k+1 for k >= 0, -k for k < 0.
  // k = scale >>> 2 spans -32..31, so a 6-bit wrap gives the right magnitude.
  function automatic logic [SHAMT_W-1:0] regime_run(input logic [SCALE_W-1:0] scale);
    logic [SHAMT_W-1:0] k;
    k = scale[SCALE_W-1:2];
    if (scale[SCALE_W-1]) begin
      return ~k + 6'd1;
    end
    return k + 6'd1;
  endfunction

endpackage

// File: rtl/posit_raw_encode_es2_if.sv
// Operand/result bundle between the raw datapath and the posit encoder.
interface posit_raw_encode_es2_if;
  import posit_raw_encode_es2_pkg::*;

  logic                   start;
  value_sum               in_sum;
  logic                   in_truncated;
  logic [POSIT_N_ES2-1:0] result;
  logic                   done;

  modport master (
    output start, in_sum, in_truncated,
    input  result, done
  );

  modport slave (
    input  start, in_sum, in_truncated,
    output result, done
  );

endinterface

// File: rtl/posit_raw_encode_es2_shift_right.sv
// Logarithmic logical right shifter; zero fill from the top.
module posit_raw_encode_es2_shift_right #(
  parameter int N = 64,
  parameter int S = 6
) (
  input  logic [N-1:0] data_i,
  input  logic [S-1:0] shamt_i,
  output logic [N-1:0] data_o
);

  logic [N-1:0] stage [S+1];

  assign stage[0] = data_i;

  for (genvar i = 0; i < S; i++) begin : g_stage
    assign stage[i+1] = shamt_i[i] ? (stage[i] >> (1 << i)) : stage[i];
  end

  assign data_o = stage[S];

endmodule

// File: rtl/posit_raw_encode_es2.sv
// Raw posit sum -> packed 32-bit es=2 posit with RNE, saturation and specials.
// Input capture, regime decode, regime shift, round/pack: 3 cycles start-to-done.
module posit_raw_encode_es2
  import posit_raw_encode_es2_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  posit_raw_encode_es2_if.slave   bus
);

  // Input capture
  logic     s0_valid_q;
  value_sum s0_in_q;
  logic     s0_trunc_q;

  // Regime decode
  logic               s1_valid_q, s1_valid_d;
  logic               s1_sgn_q;
  logic               s1_lead_q, s1_lead_d;
  logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
  logic [1:0]         s1_exp_q;
  logic [ABITS-1:0]   s1_frac_q;
  logic               s1_trunc_q;
  logic               s1_sat_hi_q, s1_sat_hi_d;
  logic               s1_sat_lo_q, s1_sat_lo_d;
  logic               s1_nar_q, s1_nar_d;
  logic               s1_zero_q, s1_zero_d;

  // Shifted string
  logic                   s2_valid_q;
  logic                   s2_sgn_q;
  logic [POSIT_N_ES2-2:0] s2_kept_q, s2_kept_d;
  logic                   s2_guard_q, s2_guard_d;
  logic                   s2_sticky_q, s2_sticky_d;
  logic                   s2_sat_hi_q, s2_sat_lo_q, s2_nar_q, s2_zero_q;

  logic [POSIT_N_ES2-1:0] result_q, result_d;
  logic                   done_q;

  logic [SHIFT_W-1:0] str_raw, sh_in, sh_out, sh_str;
  logic               round_up;
  logic [POSIT_N_ES2-1:0] rounded, mag;

  always_comb begin
    s1_valid_d  = s0_valid_q;
    s1_lead_d   = ~s0_in_q.scale[SCALE_W-1];
    s1_shamt_d  = regime_run(s0_in_q.scale);
    s1_sat_hi_d = $signed(s0_in_q.scale) > SCALE_MAX_ES2;
    s1_sat_lo_d = $signed(s0_in_q.scale) < -SCALE_MAX_ES2;
    s1_nar_d    = s0_in_q.inf;
    s1_zero_d   = ~s0_in_q.inf & s0_in_q.zero;
  end

  // The terminating regime bit is placed first; the run of lead bits comes in
  // from the top as shift fill. Ones-fill is done by inverting around the shifter.
  assign str_raw = {~s1_lead_q, s1_exp_q, s1_frac_q, {PAD_W{1'b0}}};
  assign sh_in   = s1_lead_q ? ~str_raw : str_raw;

  posit_raw_encode_es2_shift_right #(
    .N (SHIFT_W),
    .S (SHAMT_W)
  ) u_shift_right (
    .data_i  (sh_in),
    .shamt_i (s1_shamt_q),
    .data_o  (sh_out)
  );

  assign sh_str = s1_lead_q ? ~sh_out : sh_out;

  always_comb begin
    s2_kept_d   = sh_str[SHIFT_W-1 -: (POSIT_N_ES2-1)];
    s2_guard_d  = sh_str[POSIT_N_ES2];
    s2_sticky_d = (|sh_str[POSIT_N_ES2-1:0]) | s1_trunc_q;
  end

  always_comb begin
    round_up = s2_guard_q & (s2_sticky_q | s2_kept_q[0]);
    rounded  = {1'b0, s2_kept_q} + {{(POSIT_N_ES2-1){1'b0}}, round_up};
    if (s2_sat_hi_q) begin
      mag = POSIT_MAXPOS_ES2;
    end else if (s2_sat_lo_q) begin
      mag = POSIT_MINPOS_ES2;
    end else if (rounded[POSIT_N_ES2-1]) begin
      mag = POSIT_MAXPOS_ES2;
    end else if (rounded == '0) begin
      mag = POSIT_MINPOS_ES2;
    end else begin
      mag = rounded;
    end

    result_d = s2_sgn_q ? (~mag + 32'd1) : mag;
    if (s2_nar_q) begin
      result_d = POSIT_NAR_ES2;
    end else if (s2_zero_q) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      s0_valid_q <= (bus.start === 1'b1);
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s1_valid_q;
      done_q     <= s2_valid_q;
      if (s2_valid_q) begin
        result_q <= result_d;
      end
    end
  end

  // Datapath registers carry no reset; only the valid chain qualifies them.
  always_ff @(posedge clk_i) begin
    s0_in_q     <= bus.in_sum;
    s0_trunc_q  <= bus.in_truncated;

    s1_sgn_q    <= s0_in_q.sgn;
    s1_lead_q   <= s1_lead_d;
    s1_shamt_q  <= s1_shamt_d;
    s1_exp_q    <= s0_in_q.scale[1:0];
    s1_frac_q   <= s0_in_q.fraction;
    s1_trunc_q  <= s0_trunc_q;
    s1_sat_hi_q <= s1_sat_hi_d;
    s1_sat_lo_q <= s1_sat_lo_d;
    s1_nar_q    <= s1_nar_d;
    s1_zero_q   <= s1_zero_d;

    s2_sgn_q    <= s1_sgn_q;
    s2_kept_q   <= s2_kept_d;
    s2_guard_q  <= s2_guard_d;
    s2_sticky_q <= s2_sticky_d;
    s2_sat_hi_q <= s1_sat_hi_q;
    s2_sat_lo_q <= s1_sat_lo_q;
    s2_nar_q    <= s1_nar_q;
    s2_zero_q   <= s1_zero_q;
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_posit_raw_encode_es2.sv
// Directed-vector bench for the es=2 raw posit encoder.
module tb_posit_raw_encode_es2;
  import posit_raw_encode_es2_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  posit_raw_encode_es2_if bus_if ();

  posit_raw_encode_es2 dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic value_sum mk(input logic sg, input int sc, input logic [31:0] fr,
                                  input logic inf_b, input logic zr);
    value_sum v;
    v.sgn      = sg;
    v.scale    = sc[7:0];
    v.fraction = fr;
    v.inf      = inf_b;
    v.zero     = zr;
    return v;
  endfunction

  task automatic apply_op(input value_sum v, input logic tr);
    bus_if.in_sum       = v;
    bus_if.in_truncated = tr;
    bus_if.start        = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus_if.done !== 1'b1 && lat < 8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.in_sum = '0;
    bus_if.in_truncated = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", bus_if.done);
    end
    n_checks++;
    if (bus_if.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 00000000", bus_if.result);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    value_sum    v   [4];
    logic [31:0] exp [4];
    int          lat;
    v[0] = mk(1'b0, 0, 32'h0, 1'b0, 1'b0);  exp[0] = 32'h4000_0000;
    v[1] = mk(1'b0, 1, 32'h0, 1'b0, 1'b0);  exp[1] = 32'h4800_0000;
    v[2] = mk(1'b0, -1, 32'h0, 1'b0, 1'b0); exp[2] = 32'h3800_0000;
    v[3] = mk(1'b1, 0, 32'h0, 1'b0, 1'b0);  exp[3] = 32'hC000_0000;
    for (int i = 0; i < 4; i++) begin
      apply_op(v[i], 1'b0);
      wait_done(lat);
      n_checks++;
      if (lat !== 3) begin
        n_fail++;
        $display("FAIL exact_latency[%0d]: got %0d cycles want 3", i, lat);
      end
      n_checks++;
      if (bus_if.result !== exp[i]) begin
        n_fail++;
        $display("FAIL exact_value[%0d]: got %h want %h", i, bus_if.result, exp[i]);
      end
    end
  endtask

  task automatic test_specials();
    value_sum    v   [3];
    logic [31:0] exp [3];
    int          lat;
    v[0] = mk(1'b0, 5, 32'h1234_5678, 1'b1, 1'b0); exp[0] = 32'h8000_0000;
    v[1] = mk(1'b1, 3, 32'h8000_0000, 1'b0, 1'b1); exp[1] = 32'h0000_0000;
    v[2] = mk(1'b0, 0, 32'h0, 1'b1, 1'b1);         exp[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      apply_op(v[i], 1'b0);
      wait_done(lat);
      n_checks++;
      if (lat !== 3 || bus_if.result !== exp[i]) begin
        n_fail++;
        $display("FAIL special[%0d]: got %h after %0d cycles want %h after 3",
                 i, bus_if.result, lat, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    value_sum    v   [5];
    logic [31:0] exp [5];
    int          lat;
    v[0] = mk(1'b0, 127, 32'h0, 1'b0, 1'b0);  exp[0] = 32'h7FFF_FFFF;
    v[1] = mk(1'b1, 127, 32'h0, 1'b0, 1'b0);  exp[1] = 32'h8000_0001;
    v[2] = mk(1'b0, -128, 32'h0, 1'b0, 1'b0); exp[2] = 32'h0000_0001;
    v[3] = mk(1'b0, 120, 32'h0, 1'b0, 1'b0);  exp[3] = 32'h7FFF_FFFF;
    v[4] = mk(1'b0, -120, 32'h0, 1'b0, 1'b0); exp[4] = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      apply_op(v[i], 1'b0);
      wait_done(lat);
      n_checks++;
      if (lat !== 3 || bus_if.result !== exp[i]) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %h after %0d cycles want %h after 3",
                 i, bus_if.result, lat, exp[i]);
      end
    end
  endtask

  // Scale 0 keeps fraction[31:5]; fraction[4] is the guard bit.
  task automatic test_rne();
    value_sum    v   [3];
    logic        tr  [3];
    logic [31:0] exp [3];
    int          lat;
    v[0] = mk(1'b0, 0, 32'h0000_0010, 1'b0, 1'b0); tr[0] = 1'b0; exp[0] = 32'h4000_0000;
    v[1] = mk(1'b0, 0, 32'h0000_0010, 1'b0, 1'b0); tr[1] = 1'b1; exp[1] = 32'h4000_0001;
    v[2] = mk(1'b0, 0, 32'h0000_0030, 1'b0, 1'b0); tr[2] = 1'b0; exp[2] = 32'h4000_0002;
    for (int i = 0; i < 3; i++) begin
      apply_op(v[i], tr[i]);
      wait_done(lat);
      n_checks++;
      if (lat !== 3 || bus_if.result !== exp[i]) begin
        n_fail++;
        $display("FAIL rne[%0d]: got %h after %0d cycles want %h after 3",
                 i, bus_if.result, lat, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    exp[0] = 32'h2800_0000; exp[1] = 32'h3000_0000;
    exp[2] = 32'h3800_0000; exp[3] = 32'h4000_0000;
    exp[4] = 32'h4800_0000; exp[5] = 32'h5000_0000;
    exp[6] = 32'h5800_0000; exp[7] = 32'h6000_0000;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        bus_if.in_sum       = mk(1'b0, c - 3, 32'h0, 1'b0, 1'b0);
        bus_if.in_truncated = 1'b0;
        bus_if.start        = 1'b1;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (c >= 3 && c < 11) begin
        if (bus_if.done !== 1'b1 || bus_if.result !== exp[c-3]) begin
          n_fail++;
          $display("FAIL stream[%0d]: got done=%b result=%h want done=1 result=%h",
                   c - 3, bus_if.done, bus_if.result, exp[c-3]);
        end
      end else if (bus_if.done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_idle[cycle %0d]: got done=%b want 0", c, bus_if.done);
      end
    end
  endtask

  task automatic test_gap();
    logic [31:0] exp_a, exp_b;
    exp_a = 32'h5000_0000;
    exp_b = 32'h3000_0000;
    for (int c = 0; c < 9; c++) begin
      bus_if.start = (c == 0 || c == 3);
      bus_if.in_truncated = 1'b0;
      bus_if.in_sum = (c == 0) ? mk(1'b0, 2, 32'h0, 1'b0, 1'b0)
                               : mk(1'b0, -2, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_checks++;
      if (c == 3) begin
        if (bus_if.done !== 1'b1 || bus_if.result !== exp_a) begin
          n_fail++;
          $display("FAIL gap_first: got done=%b result=%h want done=1 result=%h",
                   bus_if.done, bus_if.result, exp_a);
        end
      end else if (c == 6) begin
        if (bus_if.done !== 1'b1 || bus_if.result !== exp_b) begin
          n_fail++;
          $display("FAIL gap_second: got done=%b result=%h want done=1 result=%h",
                   bus_if.done, bus_if.result, exp_b);
        end
      end else if (bus_if.done !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_idle[cycle %0d]: got done=%b want 0", c, bus_if.done);
      end
    end
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    int lat;
    int stray;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      bus_if.start = (c < 3);
      rst = (c == 2);
      bus_if.in_truncated = 1'b0;
      bus_if.in_sum = mk(1'b0, c + 1, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      if (bus_if.done !== 1'b0) stray++;
    end
    rst = 1'b0;
    bus_if.start = 1'b0;
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL reset_flush_done: got %0d done cycles want 0", stray);
    end
    n_checks++;
    if (bus_if.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_flush_result: got %h want 00000000", bus_if.result);
    end
    apply_op(mk(1'b1, 4, 32'h0, 1'b0, 1'b0), 1'b0);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || bus_if.result !== 32'hA000_0000) begin
      n_fail++;
      $display("FAIL reset_recover: got %h after %0d cycles want a0000000 after 3",
               bus_if.result, lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_exact();
    test_specials();
    test_saturation();
    test_rne();
    test_back_to_back();
    test_gap();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
